rnn_char_feeder: RTL

// - Upstream sequencer for the rnn core. Host pushes characters into a FIFO.
// - Block looks each character up in an on-chip embedding table and writes the vector to rnn addr 1.
// - Then pulses rnn START (addr 0) and polls until rnn returns to LOAD.
// - On host end-of-sequence it runs the rnn DENSE pass (addr 7), waits VALID, captures the result.

---
 rtl/rnn_char_feeder_pkg.sv | 37 +++
 rtl/rnn_char_feeder_char_fifo.sv | 54 +++++
 rtl/rnn_char_feeder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rnn_char_feeder_pkg.sv
// Shared constants and types for the rnn character feeder.
package rnn_char_feeder_pkg;

    // log2 of the rnn input vector length
    localparam int unsigned EMB_BITS = 2;

    // rnn slave word addresses
    localparam logic [2:0] RNN_A_START  = 3'd0;
    localparam logic [2:0] RNN_A_INPUT  = 3'd1;
    localparam logic [2:0] RNN_A_RESULT = 3'd7;

    // Feeder host addresses (writes)
    localparam logic [2:0] HOST_A_CHAR    = 3'd0;
    localparam logic [2:0] HOST_A_TABLE   = 3'd1;
    localparam logic [2:0] HOST_A_EOS     = 3'd2;
    localparam logic [2:0] HOST_A_OVF_CLR = 3'd3;

    // Feeder host addresses (reads)
    localparam logic [2:0] HOST_A_STATUS = 3'd0;
    localparam logic [2:0] HOST_A_RESULT = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR,
        KICK,
        POLL,
        DKICK,
        DPOLL,
        RES
    } feeder_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/rnn_char_feeder_char_fifo.sv
// Synchronous first-word-fall-through FIFO holding host characters.
module rnn_char_feeder_char_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [0:DEPTH-1];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  do_push, do_pop;

    assign full  = (count_q == (DEPTH_BITS + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A push into a full FIFO is still taken when a pop frees a slot the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/rnn_char_feeder.sv
// Feeds embedded characters into the rnn core and runs its dense pass on end-of-sequence.
module rnn_char_feeder
    import rnn_char_feeder_pkg::*;
#(
    parameter int unsigned EMB_LEN    = 4,
    parameter int unsigned VOCAB_BITS = 7,
    parameter int unsigned FIFO_BITS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        own_bus
);

    localparam int unsigned EMB_W  = (EMB_LEN > 1) ? $clog2(EMB_LEN) : 1;
    localparam int unsigned TBL_AW = VOCAB_BITS + EMB_W;
    localparam logic [EMB_W-1:0] LAST_ELEM = EMB_W'(EMB_LEN - 1);

    feeder_state_t state_q, state_d;

    logic [EMB_W-1:0]      e_q, e_d, e_nxt;
    logic [VOCAB_BITS-1:0] char_q, char_d;
    logic [15:0]           result_q, result_d;
    logic                  res_valid_q, res_valid_d;
    logic                  eos_pend_q, eos_pend_d;
    logic                  ovf_q, ovf_d;

    logic [15:0]           tbl_mem [0:(1 << TBL_AW) - 1];
    logic [15:0]           tbl_q;
    logic [TBL_AW-1:0]     tbl_raddr, tbl_waddr;
    logic                  tbl_we;

    logic                  host_push, res_rd;
    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [7:0]            fifo_rdata;
    logic [FIFO_BITS:0]    fifo_count;

    logic                  unused_bits;
    assign unused_bits = ^{fifo_rdata, data_in, m_rdata};

    assign host_push = write && (addr == HOST_A_CHAR);
    assign res_rd    = read && (addr == HOST_A_RESULT);
    assign e_nxt     = e_q + EMB_W'(1);

    rnn_char_feeder_char_fifo #(
        .WIDTH      (8),
        .DEPTH_BITS (FIFO_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host_push),
        .pop   (fifo_pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Embedding table: host may only rewrite it while the feeder is idle.
    assign tbl_we    = write && (addr == HOST_A_TABLE) && (state_q == IDLE);
    assign tbl_waddr = {data_in[24 +: VOCAB_BITS], data_in[16 +: EMB_W]};

    // Read address runs one element ahead so tbl_q holds element e during WR.
    always_comb begin
        unique case (state_q)
            IDLE:    tbl_raddr = {fifo_rdata[VOCAB_BITS-1:0], {EMB_W{1'b0}}};
            FETCH:   tbl_raddr = {char_q, {EMB_W{1'b0}}};
            default: tbl_raddr = {char_q, e_nxt};
        endcase
    end

    // Table RAM with registered read port.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_mem[tbl_waddr] <= data_in[15:0];
        end
        tbl_q <= tbl_mem[tbl_raddr];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; pending characters are drained before the dense pass.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty)     state_d = FETCH;
                else if (eos_pend_q) state_d = DKICK;
            end
            FETCH:   state_d = WR;
            WR:      if (e_q == LAST_ELEM) state_d = KICK;
            KICK:    state_d = POLL;
            POLL:    if (m_rdata[0]) state_d = IDLE;
            DKICK:   state_d = DPOLL;
            DPOLL:   if (m_rdata[0]) state_d = RES;
            RES:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master bus and pop strobes decoded from the current state.
    always_comb begin
        m_read   = 1'b0;
        m_write  = 1'b0;
        m_addr   = 3'd0;
        m_wdata  = 32'd0;
        own_bus  = (state_q != IDLE);
        fifo_pop = (state_q == IDLE) && !fifo_empty;
        unique case (state_q)
            WR: begin
                m_write = 1'b1;
                m_addr  = RNN_A_INPUT;
                m_wdata = {8'h00, 8'(e_q), tbl_q};
            end
            KICK: begin
                m_write = 1'b1;
                m_addr  = RNN_A_START;
            end
            POLL: begin
                m_read = 1'b1;
                m_addr = RNN_A_INPUT;
            end
            DKICK: begin
                m_write = 1'b1;
                m_addr  = RNN_A_RESULT;
            end
            DPOLL: begin
                m_read = 1'b1;
                m_addr = RNN_A_START;
            end
            RES: begin
                m_read = 1'b1;
                m_addr = RNN_A_RESULT;
            end
            default: ;
        endcase
    end

    // Datapath next values; RES setting res_valid overrides a same-cycle result read.
    always_comb begin
        e_d         = e_q;
        char_d      = char_q;
        result_d    = result_q;
        res_valid_d = res_valid_q;
        eos_pend_d  = eos_pend_q;
        ovf_d       = ovf_q;
        if (fifo_pop)           char_d = fifo_rdata[VOCAB_BITS-1:0];
        if (state_q == FETCH)   e_d = '0;
        else if (state_q == WR) e_d = e_nxt;
        if (write && (addr == HOST_A_EOS))     eos_pend_d = 1'b1;
        if (write && (addr == HOST_A_OVF_CLR)) ovf_d = 1'b0;
        if (host_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (res_rd) res_valid_d = 1'b0;
        if (state_q == RES) begin
            result_d    = m_rdata[15:0];
            res_valid_d = 1'b1;
            eos_pend_d  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            char_q      <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            eos_pend_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            e_q         <= e_d;
            char_q      <= char_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            eos_pend_q  <= eos_pend_d;
            ovf_q       <= ovf_d;
        end
    end

    // Host read mux; status packs own_bus at bit 0 with the FIFO count from bit 4.
    always_comb begin
        data_out = 32'd0;
        if (read) begin
            unique case (addr)
                HOST_A_STATUS: begin
                    data_out[3:0]               = {ovf_q, eos_pend_q, res_valid_q, own_bus};
                    data_out[4 +: FIFO_BITS+1]  = fifo_count;
                end
                HOST_A_RESULT: data_out = sext16(result_q);
                default:       data_out = 32'd0;
            endcase
        end
    end

endmodule
